// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating stall-cycle counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Flush,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic [REG_W-1:0]  ID_Rd,
  input  logic              ID_UsesRt,
  input  logic              ID_RegDst,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_MemToReg,
  input  logic              ID_ALUSrc,
  input  logic [3:0]        ID_ALUOp,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic [DATA_W-1:0] ID_PC,
  output logic              Stall,
  output logic [REG_W-1:0]  EX_A,
  output logic [REG_W-1:0]  EX_B,
  output logic [REG_W-1:0]  EX_Dst,
  output logic              EX_RegWrite,
  output logic              EX_MemRead,
  output logic              EX_MemWrite,
  output logic              EX_MemToReg,
  output logic              EX_ALUSrc,
  output logic [3:0]        EX_ALUOp,
  output logic [DATA_W-1:0] EX_ReadData1,
  output logic [DATA_W-1:0] EX_ReadData2,
  output logic [DATA_W-1:0] EX_Imm,
  output logic [DATA_W-1:0] EX_PC,
  output logic [CNT_W-1:0]  Stall_Count
);

  logic [REG_W-1:0]  r_a, r_b, r_dst;
  logic              r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg, r_alu_src;
  logic [3:0]        r_alu_op;
  logic [DATA_W-1:0] r_rd1, r_rd2, r_imm, r_pc;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [REG_W-1:0]  w_dst;
  logic              w_haz;
  logic              w_bubble;

  assign w_dst    = ID_RegDst ? ID_Rd : ID_Rt;
  assign w_haz    = r_mem_read && (r_dst != '0) &&
                    ((r_dst == ID_Rs) || (ID_UsesRt && (r_dst == ID_Rt)));
  assign w_bubble = Flush || w_haz;
  assign Stall    = w_haz && !Flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_dst        <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_op     <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_pc         <= '0;
    end else if (w_bubble) begin
      r_a          <= '0;
      r_b          <= '0;
      r_dst        <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_op     <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_pc         <= '0;
    end else begin
      r_a          <= ID_Rs;
      r_b          <= ID_Rt;
      r_dst        <= w_dst;
      // forwarding unit downstream never checks for r0, so kill the write here
      r_reg_write  <= ID_RegWrite && (w_dst != '0);
      r_mem_read   <= ID_MemRead;
      r_mem_write  <= ID_MemWrite;
      r_mem_to_reg <= ID_MemToReg;
      r_alu_src    <= ID_ALUSrc;
      r_alu_op     <= ID_ALUOp;
      r_rd1        <= ID_ReadData1;
      r_rd2        <= ID_ReadData2;
      r_imm        <= ID_Imm;
      r_pc         <= ID_PC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (Stall && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign EX_A         = r_a;
  assign EX_B         = r_b;
  assign EX_Dst       = r_dst;
  assign EX_RegWrite  = r_reg_write;
  assign EX_MemRead   = r_mem_read;
  assign EX_MemWrite  = r_mem_write;
  assign EX_MemToReg  = r_mem_to_reg;
  assign EX_ALUSrc    = r_alu_src;
  assign EX_ALUOp     = r_alu_op;
  assign EX_ReadData1 = r_rd1;
  assign EX_ReadData2 = r_rd2;
  assign EX_Imm       = r_imm;
  assign EX_PC        = r_pc;
  assign Stall_Count  = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, r0 suppression, load-use
// stalls, flush priority, reset mid-stall and counter saturation (CNT_W=2).
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Flush = 1'b0;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
  logic        ID_UsesRt, ID_RegDst, ID_RegWrite, ID_MemRead, ID_MemWrite;
  logic        ID_MemToReg, ID_ALUSrc;
  logic [3:0]  ID_ALUOp;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC;

  logic        Stall;
  logic [4:0]  EX_A, EX_B, EX_Dst;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc;
  logic [3:0]  EX_ALUOp;
  logic [31:0] EX_ReadData1, EX_ReadData2, EX_Imm, EX_PC;
  logic [15:0] Stall_Count;

  logic        s_Stall;
  logic [4:0]  s_A, s_B, s_Dst;
  logic        s_RegWrite, s_MemRead, s_MemWrite, s_MemToReg, s_ALUSrc;
  logic [3:0]  s_ALUOp;
  logic [31:0] s_RD1, s_RD2, s_Imm, s_PC;
  logic [1:0]  s_Count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .Flush(Flush),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_UsesRt(ID_UsesRt),
    .ID_RegDst(ID_RegDst), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .ID_MemWrite(ID_MemWrite), .ID_MemToReg(ID_MemToReg), .ID_ALUSrc(ID_ALUSrc),
    .ID_ALUOp(ID_ALUOp), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Imm(ID_Imm), .ID_PC(ID_PC),
    .Stall(Stall), .EX_A(EX_A), .EX_B(EX_B), .EX_Dst(EX_Dst),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_MemToReg(EX_MemToReg), .EX_ALUSrc(EX_ALUSrc), .EX_ALUOp(EX_ALUOp),
    .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_Imm(EX_Imm),
    .EX_PC(EX_PC), .Stall_Count(Stall_Count)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .Flush(Flush),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_UsesRt(ID_UsesRt),
    .ID_RegDst(ID_RegDst), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .ID_MemWrite(ID_MemWrite), .ID_MemToReg(ID_MemToReg), .ID_ALUSrc(ID_ALUSrc),
    .ID_ALUOp(ID_ALUOp), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Imm(ID_Imm), .ID_PC(ID_PC),
    .Stall(s_Stall), .EX_A(s_A), .EX_B(s_B), .EX_Dst(s_Dst),
    .EX_RegWrite(s_RegWrite), .EX_MemRead(s_MemRead), .EX_MemWrite(s_MemWrite),
    .EX_MemToReg(s_MemToReg), .EX_ALUSrc(s_ALUSrc), .EX_ALUOp(s_ALUOp),
    .EX_ReadData1(s_RD1), .EX_ReadData2(s_RD2), .EX_Imm(s_Imm),
    .EX_PC(s_PC), .Stall_Count(s_Count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic uses_rt, input logic reg_dst, input logic reg_write,
                        input logic mem_read, input logic mem_to_reg, input logic alu_src);
    ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; ID_UsesRt = uses_rt; ID_RegDst = reg_dst;
    ID_RegWrite = reg_write; ID_MemRead = mem_read; ID_MemWrite = 1'b0;
    ID_MemToReg = mem_to_reg; ID_ALUSrc = alu_src; ID_ALUOp = 4'h0;
    ID_ReadData1 = 32'h0; ID_ReadData2 = 32'h0; ID_Imm = 32'h0; ID_PC = 32'h0;
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".ctl"}, {59'd0, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc}, 64'd0);
    chk({tag, ".regs"}, {49'd0, EX_A, EX_B, EX_Dst}, 64'd0);
    chk({tag, ".data"}, {EX_ReadData1 | EX_ReadData2 | EX_Imm | EX_PC, 28'd0, EX_ALUOp}, 64'd0);
  endtask

  initial begin
    // reset with random ID inputs and clock running
    for (int i = 0; i < 3; i++) begin
      {ID_Rs, ID_Rt, ID_Rd} = 15'($urandom);
      {ID_UsesRt, ID_RegDst, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc} = 7'($urandom);
      ID_ALUOp = 4'($urandom);
      ID_ReadData1 = $urandom; ID_ReadData2 = $urandom; ID_Imm = $urandom; ID_PC = $urandom;
      step();
    end
    chk_bubble("reset");
    chk("reset.stall", {63'd0, Stall}, 64'd0);
    chk("reset.cnt", {48'd0, Stall_Count}, 64'd0);
    rst_n = 1'b1;

    // R-type pass-through, RegDst=1
    id_set(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ID_ALUOp = 4'h2; ID_ReadData1 = 32'h1111_1111; ID_ReadData2 = 32'h2222_2222;
    ID_Imm = 32'hFFFF_FFF0; ID_PC = 32'h0000_0104;
    step();
    chk("pass.regs", {49'd0, EX_A, EX_B, EX_Dst}, {49'd0, 5'd3, 5'd4, 5'd5});
    chk("pass.regwrite", {63'd0, EX_RegWrite}, 64'd1);
    chk("pass.aluop", {60'd0, EX_ALUOp}, 64'h2);
    chk("pass.rd", {EX_ReadData1, EX_ReadData2}, 64'h1111_1111_2222_2222);
    chk("pass.immpc", {EX_Imm, EX_PC}, 64'hFFFF_FFF0_0000_0104);

    // RegDst=0 selects Rt
    id_set(5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk("rt_dst.dst", {59'd0, EX_Dst}, 64'd4);
    chk("rt_dst.ctl", {59'd0, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc}, 64'b10011);

    // write to r0 suppressed
    id_set(5'd3, 5'd4, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("r0.dst", {59'd0, EX_Dst}, 64'd0);
    chk("r0.regwrite", {63'd0, EX_RegWrite}, 64'd0);

    // load r8, then dependent Rs=8
    id_set(5'd2, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("load.nostall", {63'd0, Stall}, 64'd0);
    step();
    chk("load.ex", {58'd0, EX_MemRead, EX_Dst}, {58'd0, 1'b1, 5'd8});
    id_set(5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu.stall", {63'd0, Stall}, 64'd1);
    step();
    chk_bubble("lu.bubble");
    chk("lu.cnt", {48'd0, Stall_Count}, 64'd1);
    chk("lu.stall_drop", {63'd0, Stall}, 64'd0);
    step();
    chk("lu.issue", {54'd0, EX_A, EX_Dst}, {54'd0, 5'd8, 5'd10});

    // Rt match but Rt not used
    id_set(5'd2, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    id_set(5'd1, 5'd8, 5'd11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rt_unused.stall", {63'd0, Stall}, 64'd0);
    step();
    chk("rt_unused.ex", {54'd0, EX_A, EX_Dst}, {54'd0, 5'd1, 5'd11});
    chk("rt_unused.cnt", {48'd0, Stall_Count}, 64'd1);

    // Rt match with Rt used (store-like)
    id_set(5'd2, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    id_set(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rt_used.stall", {63'd0, Stall}, 64'd1);
    step();
    chk("rt_used.cnt", {48'd0, Stall_Count}, 64'd2);

    // back-to-back dependent loads: one stall only
    id_set(5'd2, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    id_set(5'd8, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("b2b.stall1", {63'd0, Stall}, 64'd1);
    step();
    chk("b2b.stall2", {63'd0, Stall}, 64'd0);
    chk("b2b.cnt", {48'd0, Stall_Count}, 64'd3);
    step();
    chk("b2b.ex", {58'd0, EX_MemRead, EX_Dst}, {58'd0, 1'b1, 5'd9});

    // flush wins over hazard
    id_set(5'd9, 5'd1, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    Flush = 1'b1;
    #1;
    chk("flush.stall", {63'd0, Stall}, 64'd0);
    step();
    Flush = 1'b0;
    chk_bubble("flush.bubble");
    chk("flush.cnt", {48'd0, Stall_Count}, 64'd3);

    // load into r0 never causes a stall
    id_set(5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    id_set(5'd0, 5'd0, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("r0load.stall", {63'd0, Stall}, 64'd0);

    // reset mid-stall drops Stall immediately
    id_set(5'd2, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    id_set(5'd8, 5'd1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_mid.stall_pre", {63'd0, Stall}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid.stall", {63'd0, Stall}, 64'd0);
    chk_bubble("rst_mid.ex");
    chk("rst_mid.cnt", {48'd0, Stall_Count}, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_mid.restart", {54'd0, EX_A, EX_Dst}, {54'd0, 5'd8, 5'd3});

    // five stalls: 16-bit counter reaches 5, 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      id_set(5'd2, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      id_set(5'd8, 5'd1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("sat.stall", {62'd0, Stall, s_Stall}, 64'b11);
      step();
      if (i == 2) chk("sat.cnt3", {62'd0, s_Count}, 64'd3);
    end
    chk("sat.cnt_small", {62'd0, s_Count}, 64'd3);
    chk("sat.cnt_big", {48'd0, Stall_Count}, 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection; it sits directly upstream of the EX-stage forwarding unit.
- It registers decoded operands and control and drives EX_A, EX_B, EXMEM-bound destination and RegWrite.
- It detects load-use hazards, requests an IF/ID stall and inserts bubbles.
- It counts stall cycles for performance monitoring.

Parameters:
DATA_W, 32, width of register data, immediate and PC
REG_W, 5, register address width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
Flush  in  1  branch/jump squash; next EX contents become a bubble
ID_Rs  in  REG_W  decoded source register A
ID_Rt  in  REG_W  decoded source register B
ID_Rd  in  REG_W  decoded R-type destination
ID_UsesRt  in  1  instruction reads Rt as a source (R-type, store, branch)
ID_RegDst  in  1  1: destination = Rd, 0: destination = Rt
ID_RegWrite  in  1  instruction writes the register file
ID_MemRead  in  1  load
ID_MemWrite  in  1  store
ID_MemToReg  in  1  writeback selects memory data
ID_ALUSrc  in  1  ALU B operand selects immediate
ID_ALUOp  in  4  ALU operation code
ID_ReadData1  in  DATA_W  register file port 1
ID_ReadData2  in  DATA_W  register file port 2
ID_Imm  in  DATA_W  sign-extended immediate
ID_PC  in  DATA_W  PC+4 of the instruction
Stall  out  1  hold PC and IF/ID this cycle (combinational)
EX_A  out  REG_W  registered Rs (to forwarding unit)
EX_B  out  REG_W  registered Rt (to forwarding unit)
EX_Dst  out  REG_W  registered selected destination
EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc  out  1 each  registered control
EX_ALUOp  out  4  registered ALU op
EX_ReadData1, EX_ReadData2, EX_Imm, EX_PC  out  DATA_W each  registered data
Stall_Count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst_n low, asynchronous): all EX_* outputs and Stall_Count go to 0, i.e. a bubble. Stall = 0 while in reset.
- Hazard (combinational from registered state):
  - haz = EX_MemRead & (EX_Dst != 0) & ((EX_Dst == ID_Rs) | (ID_UsesRt & (EX_Dst == ID_Rt))).
  - Stall = haz & ~Flush.
- Destination select: Dst = ID_RegDst ? ID_Rd : ID_Rt.
- Write-to-r0 suppression: if Dst == 0, the loaded EX_RegWrite = 0. This is required because the forwarding unit does not check for r0.
- Per-edge update priority:
  1. Flush = 1: load bubble.
  2. haz = 1: load bubble. Stall_Count increments.
  3. Otherwise: load all ID_* fields, with Dst and RegWrite as above.
- Bubble: every EX_* control bit, EX_ALUOp, EX_A, EX_B and EX_Dst are 0. Data fields are also loaded with 0.
- Latency: 1 cycle from ID_* to EX_*. A stalled instruction enters EX exactly 1 cycle later; the load-use penalty is 1 bubble.
- Stall_Count:
  - Increments only when Stall is 1.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- Flush with a simultaneous hazard: a bubble is loaded, Stall = 0 and the counter does not increment.
- Back-to-back loads: a load following a load with a dependency stalls once. The bubble has MemRead = 0, so no second stall occurs.
- Reset mid-stall: Stall drops immediately (asynchronous clear of EX_MemRead), and the pipeline restarts from a bubble.

Test Plan:
1. Reset: hold rst_n = 0 with random ID inputs and clocks running -> all EX_* = 0, Stall = 0, Stall_Count = 0. Release -> the next edge loads the ID inputs.
2. Pass-through: R-type Rs=3, Rt=4, Rd=5, RegDst=1, RegWrite=1 -> after 1 edge EX_A=3, EX_B=4, EX_Dst=5, EX_RegWrite=1. Repeat with RegDst=0 -> EX_Dst=4.
3. r0 suppression: RegDst=1, Rd=0, RegWrite=1 -> EX_Dst=0, EX_RegWrite=0.
4. Load-use:
   - Load with Rt=8 into EX, then ID_Rs=8 -> Stall=1 for exactly 1 cycle. EX becomes a bubble and Stall_Count=1. Next edge EX_A=8.
   - With ID_Rt=8 and ID_UsesRt=0 -> no stall.
5. Flush priority: load-use condition and Flush=1 in the same cycle -> Stall=0, EX = bubble, Stall_Count unchanged.
6. Saturation: CNT_W=2, force 5 stall cycles -> Stall_Count ends at 3.
